// File: rtl/peripheral_keypad_4x4_if.sv
// Peripheral bus bundle for the 4x4 keypad reader.
// WD/WE written by the CPU, RD/key_valid returned by the keypad.
interface peripheral_keypad_4x4_if;
  logic [1:0]  WD;
  logic        WE;
  logic [31:0] RD;
  logic        key_valid;

  modport master (
    output WD, WE,
    input  RD, key_valid
  );

  modport slave (
    input  WD, WE,
    output RD, key_valid
  );
endinterface

// File: rtl/peripheral_keypad_4x4.sv
// 4x4 matrix keypad scanner with frame debounce and a latched key code.
// Status is read over the WD/WE/RD peripheral bus; key_valid is the IRQ.
module peripheral_keypad_4x4 #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  peripheral_keypad_4x4_if.slave bus
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STB_MAX  = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STB_PRE  = SW'(DEBOUNCE_SCANS - 1);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  logic [3:0]    rows_s1;
  logic [3:0]    rows_s2;
  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [15:0]   frame;
  logic          frame_done;
  logic [15:0]   prev;
  logic [SW-1:0] stable;
  logic [15:0]   map;
  logic [3:0]    code;
  logic          valid;
  logic          overrun;
  state_t        state;

  logic [3:0]    p;
  logic          last;
  logic          same;
  logic          upd;
  logic          one_hot;
  logic          ev;
  logic          clr_v;
  logic          clr_o;
  logic          any_k;
  logic          multi;
  logic [SW-1:0] stb_nxt;

  function automatic logic [3:0] enc(input logic [15:0] f);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++)
      if (f[i]) r = 4'(i);
    return r;
  endfunction

  assign p       = ~rows_s2;
  assign last    = (div == DIV_LAST);
  assign same    = (frame == prev);
  assign stb_nxt = (stable == STB_MAX) ? stable : stable + SW'(1);
  assign upd     = frame_done && same && (stable == STB_PRE);
  assign one_hot = (frame != 16'd0) &&
                   ((frame & (frame - 16'd1)) == 16'd0);
  assign ev      = upd && (state == IDLE) && one_hot;
  assign clr_v   = bus.WE & bus.WD[0];
  assign clr_o   = bus.WE & bus.WD[1];
  assign any_k   = (map != 16'd0);
  assign multi   = any_k && ((map & (map - 16'd1)) != 16'd0);

  assign bus.RD        = {map, 8'h00, any_k, multi, overrun, valid, code};
  assign bus.key_valid = valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_s1    <= 4'hF;
      rows_s2    <= 4'hF;
      div        <= '0;
      col        <= 2'd0;
      cols       <= 4'b1110;
      frame      <= 16'd0;
      frame_done <= 1'b0;
      prev       <= 16'd0;
      stable     <= '0;
      map        <= 16'd0;
      code       <= 4'd0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      state      <= IDLE;
    end else begin
      rows_s1    <= rows;
      rows_s2    <= rows_s1;
      div        <= last ? '0 : div + DW'(1);
      frame_done <= last && (col == 2'd3);
      if (last) begin
        frame[{col, 2'b00} +: 4] <= p;
        col  <= col + 2'd1;
        cols <= ~(4'b0001 << (col + 2'd1));
      end
      // Frame is final one cycle after the col-3 sample; never overlaps a sample.
      if (frame_done) begin
        frame  <= 16'd0;
        prev   <= frame;
        stable <= same ? stb_nxt : '0;
        if (upd) begin
          map <= frame;
          unique case (state)
            IDLE: if (frame != 16'd0) state <= HELD;
            HELD: if (frame == 16'd0) state <= IDLE;
          endcase
        end
      end
      if (clr_v) valid   <= 1'b0;
      if (clr_o) overrun <= 1'b0;
      if (ev) begin
        valid <= 1'b1;
        code  <= enc(frame);
        if (valid && !clr_v) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_keypad_4x4.sv
// Scoreboard bench for peripheral_keypad_4x4 (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// A keypad model drives rows from cols; RD changes are checked in order.
module tb_peripheral_keypad_4x4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] pressed;
  logic [15:0] pe;
  logic        bounce_en;
  logic        bnc;
  logic [1:0]  bcnt;
  int          cyc;
  int          checks;
  int          failures;
  logic        mon_en;
  logic [31:0] last_rd;
  logic [31:0] exp_q[$];

  peripheral_keypad_4x4_if bus();

  peripheral_keypad_4x4 #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rows  (rows),
    .cols  (cols),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign pe = pressed | {15'd0, bounce_en & bnc};

  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!cols[c])
        for (int r = 0; r < 4; r++)
          if (pe[4*c+r]) rows[r] = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= rst_n ? cyc + 1 : 0;
    if (!bounce_en) begin
      bcnt <= 2'd0;
      bnc  <= 1'b0;
    end else if (bcnt == 2'd2) begin
      bcnt <= 2'd0;
      bnc  <= ~bnc;
    end else begin
      bcnt <= bcnt + 2'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && bus.RD !== last_rd) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected_change", bus.RD, last_rd);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("rd_seq", bus.RD, e);
        chk("key_valid", {31'd0, bus.key_valid}, {31'd0, e[4]});
      end
      last_rd <= bus.RD;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  task automatic align();
    int g;
    g = 0;
    while ((cyc % 16) != 1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) timeout("align");
  endtask

  task automatic press(input logic [15:0] m, output int t0);
    align();
    pressed = m;
    t0 = cyc;
  endtask

  task automatic release_all();
    align();
    pressed = 16'd0;
  endtask

  task automatic bus_write(input logic [1:0] d);
    bus.WE = 1'b1;
    bus.WD = d;
    @(negedge clk);
    bus.WE = 1'b0;
    bus.WD = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int g;
    checks    = 0;
    failures  = 0;
    mon_en    = 1'b0;
    last_rd   = 32'd0;
    pressed   = 16'd0;
    bounce_en = 1'b0;
    bus.WE    = 1'b0;
    bus.WD    = 2'b00;
    rst_n     = 1'b0;
    tick(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // idle scan after reset
    chk("reset_rd", bus.RD, 32'd0);
    chk("reset_kv", {31'd0, bus.key_valid}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << ((k / 4) % 4));
      chk("cols_scan", {28'd0, cols}, {28'd0, ec});
      chk("idle_rd", bus.RD, 32'd0);
      tick(1);
    end
    tick(84);
    chk("idle_rd_end", bus.RD, 32'd0);

    // key 9 held, update exactly after third identical frame
    exp_q.push_back(32'h0200_0099);
    press(16'h0200, t0);
    tick(47);
    chk("k9_before_map", {16'd0, bus.RD[31:16]}, 32'd0);
    tick(1);
    chk("k9_map", {16'd0, bus.RD[31:16]}, 32'h0000_0200);
    chk("k9_code", {28'd0, bus.RD[3:0]}, 32'd9);
    tick(32);
    exp_q.push_back(32'h0200_0089);
    bus_write(2'b01);
    exp_q.push_back(32'h0000_0009);
    release_all();
    tick(64);

    // bouncing key never debounces
    align();
    bounce_en = 1'b1;
    tick(64);
    bounce_en = 1'b0;
    tick(64);
    chk("bounce_rd", bus.RD, 32'h0000_0009);
    exp_q.push_back(32'h0001_0090);
    press(16'h0001, t0);
    tick(64);
    exp_q.push_back(32'h0000_0010);
    release_all();
    tick(64);

    // overrun on second key without clear
    exp_q.push_back(32'h0000_0000);
    bus_write(2'b01);
    exp_q.push_back(32'h0200_0099);
    press(16'h0200, t0);
    tick(64);
    exp_q.push_back(32'h0000_0019);
    release_all();
    tick(64);
    exp_q.push_back(32'h0010_00B4);
    press(16'h0010, t0);
    tick(64);
    exp_q.push_back(32'h0010_0084);
    bus_write(2'b11);
    exp_q.push_back(32'h0000_0004);
    release_all();
    tick(64);

    // two keys from idle: multi, no event
    exp_q.push_back(32'h0042_00C4);
    press(16'h0042, t0);
    tick(64);
    exp_q.push_back(32'h0002_0084);
    align();
    pressed = 16'h0002;
    tick(64);
    exp_q.push_back(32'h0000_0004);
    release_all();
    tick(64);
    exp_q.push_back(32'h0040_0096);
    press(16'h0040, t0);
    tick(64);
    exp_q.push_back(32'h0000_0016);
    release_all();
    tick(64);

    // clear write on the same edge as a key event
    exp_q.push_back(32'h0008_0093);
    press(16'h0008, t0);
    tick(47);
    bus.WE = 1'b1;
    bus.WD = 2'b01;
    tick(1);
    bus.WE = 1'b0;
    bus.WD = 2'b00;
    chk("clr_race_low", {26'd0, bus.RD[5:0]}, 32'h0000_0013);
    exp_q.push_back(32'h0000_0013);
    release_all();
    tick(64);

    // reset mid-frame with a key held
    exp_q.push_back(32'h0200_00B9);
    press(16'h0200, t0);
    tick(64);
    g = 0;
    while ((cyc % 16) != 8 && g < 40) begin
      tick(1);
      g++;
    end
    if (g >= 40) timeout("midframe");
    exp_q.push_back(32'h0000_0000);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst_rd", bus.RD, 32'd0);
    chk("rst_cols", {28'd0, cols}, 32'h0000_000E);
    exp_q.push_back(32'h0200_0099);
    tick(48);
    chk("rst_before_map", {16'd0, bus.RD[31:16]}, 32'd0);
    tick(1);
    chk("rst_redetect", {16'd0, bus.RD[31:16]}, 32'h0000_0200);
    tick(4);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peripheral_keypad_4x4.md
Name: peripheral_keypad_4x4

Overview:
- Memory-mapped 4x4 matrix keypad reader. It is the input-side counterpart of the 7-segment output peripheral.
- Drives active-low column strobes, samples active-low rows and debounces whole-matrix frames.
- Latches one key code per press into a status register that the CPU reads over the same WD/WE/RD peripheral bus.
- key_valid is available as an interrupt request.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is held low before its rows are sampled (>=2).
- DEBOUNCE_SCANS, 4, consecutive identical full frames required before the debounced key map updates (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- WD  input  2  write data: bit0 = clear valid, bit1 = clear overrun
- WE  input  1  write enable, sampled at posedge clk
- rows  input  4  keypad rows, active-low (pulled up externally), asynchronous
- cols  output  4  keypad column strobes, one-hot-low
- RD  output  32  status register, combinational from internal registers
- key_valid  output  1  equals the valid bit

Behaviour:
- Reset (rst_n=0 at posedge):
  - cols=4'b1110; column index=0; divider=0.
  - Row synchronizer=4'b1111; frame accumulator=0; previous frame=0; stable count=0.
  - Debounced map=0; code=0; valid=0; overrun=0; FSM=IDLE.
  - RD=0 and key_valid=0 on the cycle after the reset edge.
  - Reset asserted mid-scan or mid-debounce discards everything; scanning restarts at column 0.
- Synchronizer: rows pass through 2 flops. The sampled value is p = ~rows_sync (1 = pressed).
- Scan divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On the cycle where divider==SCAN_DIV-1:
    - Write p into frame bits [4*col+3 : 4*col].
    - Advance col 0->1->2->3->0.
    - cols becomes ~(1<<new col) on the same edge.
- Frame complete: on the sampling edge of col 3 the frame is final (the col-3 bits use p from that edge). The debounce step below runs on the next cycle, and the frame accumulator clears to 0 at the same time. One frame = 4*SCAN_DIV cycles.
- Debounce step:
  - If frame==previous: stable = min(stable+1, DEBOUNCE_SCANS). Otherwise stable=0.
  - previous <= frame.
  - When stable reaches DEBOUNCE_SCANS (transition edge only), debounced map <= frame.
- Key index: bit 4*col+row. The code is that 4-bit index.
- FSM, evaluated on each debounced map update:
  - IDLE: map has exactly one bit set -> latch code, raise key event, go HELD. Map has 2 or more bits set -> go HELD with no event. Map is 0 -> stay.
  - HELD: map becomes 0 -> IDLE. Any other change -> stay in HELD, no event. A new key needs a full release first; there is no auto-repeat.
- Key event:
  - Sets valid=1.
  - If valid was already 1 and is not being cleared this cycle, also set overrun=1.
  - code is always overwritten with the newest key.
- Bus writes, WE=1:
  - WD[0]=1 clears valid. WD[1]=1 clears overrun.
  - A key event on the same edge wins: valid ends at 1, code is new, and overrun is not set by that event.
- RD layout:
  - [3:0] code
  - [4] valid
  - [5] overrun
  - [6] multi (debounced map has 2 or more bits set)
  - [7] any (debounced map nonzero)
  - [15:8] zero
  - [31:16] debounced map
- Reads have no side effects.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 cycles):
- Reset with rows=4'hF, hold 100 cycles:
  - cols cycles E,D,B,7, each held 4 cycles.
  - RD=0 and key_valid=0 throughout.
- Hold key col2/row1 (rows[1]=0 only while cols[2]=0) for 5 frames:
  - RD[31:16]=16'h0200, RD[3:0]=9, valid=1, any=1.
  - The update lands exactly after the 3rd identical frame completes.
- Key bounces (toggles every 3 cycles) for 4 frames, then stays released:
  - No debounced map update and valid stays 0.
  - Then press col0/row0 stably: code=0, valid=1.
- Press code 9, release, then press code 4 without a clear:
  - code=4, valid=1, overrun=1.
  - WE=1, WD=2'b11 -> RD[5:4]=0.
- Keys 1 and 6 pressed together from idle:
  - map=16'h0042, multi=1, valid stays 0.
  - Release key 6 only: no event. Release all, press 6: code=6, valid=1.
- Clear write (WE=1, WD=1) on the same edge as a key event for code 3:
  - valid=1, code=3, overrun=0.
- rst_n=0 for 1 cycle mid-frame while a key is held:
  - Next cycle RD=0 and cols=E.
  - The key is re-detected after 3 clean frames.
